keyboard_tx: RTL and testbench
==============================

KEYBOARD_TX -- requirements
Module: keyboard_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 25000000, CLK frequency in Hz.
REQ-002 SHALL have parameter INHIBIT_CYCLES, default 2500, number of CLK cycles the host holds keyboard_clock low (100 us at default CLK).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, maximum CLK cycles allowed between consecutive device clock falling edges (2 ms at default CLK).
REQ-004 SHALL have port CLK  input  1  single system clock; all logic is on its rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port tx_data  input  8  command byte to send to the keyboard.
REQ-007 SHALL have port tx_valid  input  1  request to send tx_data.
REQ-008 SHALL have port tx_ready  output  1  block is idle and accepts a request.
REQ-009 SHALL have port tx_done  output  1  one-cycle pulse on acknowledged completion.
REQ-010 SHALL have port tx_error  output  1  one-cycle pulse on timeout or missing ACK.
REQ-011 SHALL have port busy  output  1  high whenever a transfer is in progress; the keyboard receiver ignores the line while it is high.
REQ-012 SHALL have port keyboard_clock  input  1  raw PS/2 clock line level.
REQ-013 SHALL have port keyboard_data  input  1  raw PS/2 data line level.
REQ-014 SHALL have port keyboard_clock_oe  output  1  1 = pull the clock line low, 0 = release it.
REQ-015 SHALL have port keyboard_data_oe  output  1  1 = pull the data line low, 0 = release it.

Function
REQ-016 SHALL pass keyboard_clock and keyboard_data through 2-FF synchronizers; a falling edge is sync_clk==0 with previous sync_clk==1.
REQ-017 SHALL implement states IDLE, INHIBIT, REQUEST, BITS, ACK, RELEASE.
REQ-018 SHALL assert tx_ready only in IDLE and accept a request when tx_valid && tx_ready, then latch tx_data and compute odd parity (parity = ~^tx_data).
REQ-019 SHALL ignore tx_valid in every state other than IDLE; no queueing.
REQ-020 INHIBIT SHALL drive keyboard_clock_oe=1 and keyboard_data_oe=0 for exactly INHIBIT_CYCLES cycles.
REQ-021 SHALL go to REQUEST for 1 cycle with both oe=1, so data goes low before clock is released, then to BITS with clock_oe=0 and data_oe=1 (start bit).
REQ-022 In BITS, on falling edges 1..8, data_oe SHALL be set to ~bit[n-1] (LSB first); on edge 9 to ~parity; on edge 10 to 0 (stop bit); the machine then enters ACK.
REQ-023 In ACK, on falling edge 11 the block SHALL sample sync_data: 0 -> RELEASE; 1 -> tx_error pulse, IDLE.
REQ-024 RELEASE SHALL wait for sync_clk==1 && sync_data==1, then pulse tx_done and return to IDLE.
REQ-025 A timeout counter SHALL clear on entry to BITS and on every falling edge.
REQ-026 If the timeout counter reaches TIMEOUT_CYCLES in BITS, ACK or RELEASE, the block SHALL release both lines, pulse tx_error and go to IDLE.
REQ-027 tx_done and tx_error SHALL never be high in the same cycle, and each pulse SHALL be exactly 1 cycle.
REQ-028 busy SHALL equal state!=IDLE; both oe outputs SHALL be 0 in IDLE.
REQ-029 The edge counter SHALL be 4 bits, cleared on entry to BITS, and SHALL saturate rather than wrap.

Reset
REQ-030 While resetn=0, asynchronously: state=IDLE, keyboard_clock_oe=0, keyboard_data_oe=0, tx_done=0, tx_error=0, busy=0, tx_ready=1, all counters and synchronizers cleared to their idle levels (sync regs=1).
REQ-031 Reset asserted mid-transfer SHALL release both lines immediately, with no tx_done or tx_error pulse.

Verification
REQ-032 Send 0xED with a device model that ACKs -> clock_oe high for 2500 cycles; data bits 1,0,1,1,0,1,1,1; parity 1; stop released; tx_done pulse 1 cycle after lines are high.
REQ-033 Send 0x01 -> parity bit 0. Send 0xFF -> parity bit 1. Both complete with tx_done.
REQ-034 Device model never clocks after REQUEST -> tx_error exactly 50000 cycles after entry to BITS; both oe=0; tx_ready=1.
REQ-035 Device holds data high at edge 11 -> tx_error pulse, no tx_done, back to IDLE.
REQ-036 tx_valid pulsed during BITS with 0x55 -> ignored; the current byte completes unchanged and tx_ready stays 0.
REQ-037 resetn pulsed low at falling edge 5 -> both oe=0 in the same cycle, no pulses; the next request 0xF4 completes normally.

Source files
------------

// File: rtl/keyboard_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a request-to-send,
// shifts out one byte with odd parity on device clock edges, then checks the ACK.
module keyboard_tx #(
    parameter int CLK_FREQ_HZ    = 25000000,
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       keyboard_clock,
    input  logic       keyboard_data,
    output logic       keyboard_clock_oe,
    output logic       keyboard_data_oe,
    output logic [2:0] o_dbg_state
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_REQUEST = 3'd2;
    localparam logic [2:0] S_BITS    = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    if (CLK_FREQ_HZ < 1 || INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("keyboard_tx: invalid parameter values");
    end

    logic             r_clk_s1, r_clk_s2, r_clk_prev;
    logic             r_dat_s1, r_dat_s2;
    logic [2:0]       r_state;
    logic [INH_W-1:0] r_inh_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [3:0]       r_edge_cnt;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic             r_clk_oe, r_data_oe;
    logic             r_done, r_error;

    logic             w_fall;
    logic             w_timeout;
    logic             w_ready;
    logic [3:0]       w_edge_next;

    // Sync registers idle high so reset never fakes a falling edge.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= keyboard_clock;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= keyboard_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall      = r_clk_prev & ~r_clk_s2;
    assign w_timeout   = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !w_fall;
    assign w_ready     = (r_state == S_IDLE);
    assign w_edge_next = (r_edge_cnt == 4'hF) ? 4'hF : r_edge_cnt + 4'd1;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_inh_cnt  <= '0;
            r_to_cnt   <= '0;
            r_edge_cnt <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (tx_valid && w_ready) begin
                        r_shift   <= tx_data;
                        r_parity  <= ~^tx_data;
                        r_inh_cnt <= '0;
                        r_clk_oe  <= 1'b1;
                        r_state   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                        r_data_oe <= 1'b1;
                        r_state   <= S_REQUEST;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + 1'b1;
                    end
                end
                S_REQUEST: begin
                    // Data is already low; releasing clock now forms the start bit.
                    r_clk_oe   <= 1'b0;
                    r_to_cnt   <= '0;
                    r_edge_cnt <= '0;
                    r_state    <= S_BITS;
                end
                S_BITS: begin
                    if (w_timeout) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_error   <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (w_fall) begin
                        r_edge_cnt <= w_edge_next;
                        r_to_cnt   <= '0;
                        if (w_edge_next <= 4'd8) begin
                            r_data_oe <= ~r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end else if (w_edge_next == 4'd9) begin
                            r_data_oe <= ~r_parity;
                        end else begin
                            r_data_oe <= 1'b0;
                            r_state   <= S_ACK;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    if (w_timeout) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_error   <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (w_fall) begin
                        r_edge_cnt <= w_edge_next;
                        r_to_cnt   <= '0;
                        if (!r_dat_s2) begin
                            r_state <= S_RELEASE;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (w_timeout) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_error   <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (r_clk_s2 && r_dat_s2) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_fall) begin
                        r_to_cnt <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready          = w_ready;
    assign busy              = ~w_ready;
    assign tx_done           = r_done;
    assign tx_error          = r_error;
    assign keyboard_clock_oe = r_clk_oe;
    assign keyboard_data_oe  = r_data_oe;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_keyboard_tx.sv
// Directed bench for keyboard_tx: an open-collector PS/2 device model clocks the
// frame out, and a vector table drives the normal transfers.
module tb_keyboard_tx;

    localparam int INH = 2500;
    localparam int TO  = 10000;
    localparam int H   = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       keyboard_clock, keyboard_data;
    logic       keyboard_clock_oe, keyboard_data_oe;
    logic [2:0] dbg_state;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    assign keyboard_clock = dev_clk & ~keyboard_clock_oe;
    assign keyboard_data  = dev_data & ~keyboard_data_oe;

    keyboard_tx #(
        .CLK_FREQ_HZ   (25000000),
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK              (clk),
        .resetn           (resetn),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .tx_done          (tx_done),
        .tx_error         (tx_error),
        .busy             (busy),
        .keyboard_clock   (keyboard_clock),
        .keyboard_data    (keyboard_data),
        .keyboard_clock_oe(keyboard_clock_oe),
        .keyboard_data_oe (keyboard_data_oe),
        .o_dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic       exp_par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[5];

    int   done_cnt = 0, err_cnt = 0, overlap_cnt = 0, wide_cnt = 0;
    logic prev_done = 1'b0, prev_err = 1'b0;

    always @(negedge clk) begin
        if (tx_done && tx_error) overlap_cnt++;
        if ((tx_done && prev_done) || (tx_error && prev_err)) wide_cnt++;
        if (tx_done && !prev_done) done_cnt++;
        if (tx_error && !prev_err) err_cnt++;
        prev_done = tx_done;
        prev_err  = tx_error;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        exp_q.push_back(d);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic measure_request(output int inh, output int req);
        inh = 0;
        while (keyboard_clock_oe && !keyboard_data_oe && inh < INH + 10) begin
            inh++;
            @(negedge clk);
        end
        req = 0;
        while (keyboard_clock_oe && keyboard_data_oe && req < 5) begin
            req++;
            @(negedge clk);
        end
    endtask

    task automatic device(input bit ack, input bit poke, output logic [7:0] b,
                          output logic par, output logic stp);
        b = 8'h00; par = 1'bx; stp = 1'bx;
        repeat (H) @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            if (poke && k == 3) begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge clk);
                check("ready_in_bits", tx_ready, 1'b0);
                tx_valid = 1'b0;
                repeat (H - 1) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            if (k <= 8) b[k-1] = keyboard_data;
            else if (k == 9) par = keyboard_data;
            else stp = keyboard_data;
        end
        if (ack) dev_data = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic run_vector(input vec_t v, input bit poke);
        int inh, req, lat, base_d, base_e;
        logic [7:0] got;
        logic par, stp, exp_b;
        base_d = done_cnt;
        base_e = err_cnt;
        start_tx(v.data);
        measure_request(inh, req);
        check("inhibit_len", inh, INH);
        check("request_len", req, 1);
        device(v.ack, poke, got, par, stp);
        exp_b = 1'b0;
        if (exp_q.size() > 0) check("data_bits", got, exp_q.pop_front());
        else check("exp_queue_empty", 0, 1);
        check("parity_bit", par, v.exp_par);
        check("stop_bit", stp, 1'b1);
        lat = 0;
        while (!tx_done && (done_cnt + err_cnt) == (base_d + base_e) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (v.ack) check("done_latency", lat, 3);
        @(negedge clk);
        check("done_pulses", done_cnt - base_d, v.exp_done);
        check("error_pulses", err_cnt - base_e, v.exp_err);
        check("ready_after", tx_ready, 1'b1);
        check("oe_after", {keyboard_clock_oe, keyboard_data_oe}, 2'b00);
        if (poke) begin
            repeat (10) @(negedge clk);
            check("no_queued_tx", busy, 1'b0);
        end
    endtask

    initial begin
        int cnt, base_d, base_e, inh, req;
        vecs[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1, 0};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 1, 0};
        vecs[4] = '{8'hA7, 1'b0, 1'b0, 0, 1};

        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_oe", {keyboard_clock_oe, keyboard_data_oe}, 2'b00);
        check("rst_pulses", {tx_done, tx_error}, 2'b00);
        check("rst_state", dbg_state, 3'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vector(vecs[i], 1'b0);

        // Request during BITS must be dropped; the first byte finishes intact.
        run_vector(vecs[0], 1'b1);

        // Device never clocks: timeout counted from entry to BITS.
        base_e = err_cnt;
        start_tx(8'h12);
        cnt = 0;
        while (dbg_state != 3'd3 && cnt < INH + 20) begin
            @(negedge clk);
            cnt++;
        end
        check("reach_bits", dbg_state, 3'd3);
        cnt = 0;
        while (!tx_error && cnt < TO + 50) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_cycles", cnt, TO);
        check("timeout_oe", {keyboard_clock_oe, keyboard_data_oe}, 2'b00);
        check("timeout_ready", tx_ready, 1'b1);
        @(negedge clk);
        check("timeout_err_pulses", err_cnt - base_e, 1);
        exp_q.delete();

        // Reset asserted right after falling edge 5 of an 0xED frame.
        start_tx(8'hED);
        measure_request(inh, req);
        repeat (H) @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            dev_clk = 1'b0;
            if (k < 5) begin
                repeat (H) @(negedge clk);
                dev_clk = 1'b1;
                repeat (H) @(negedge clk);
            end
        end
        repeat (3) @(negedge clk);
        check("edge5_data_oe", keyboard_data_oe, 1'b1);
        base_d = done_cnt;
        base_e = err_cnt;
        resetn = 1'b0;
        #1;
        check("midrst_oe", {keyboard_clock_oe, keyboard_data_oe}, 2'b00);
        check("midrst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        resetn  = 1'b1;
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_pulses", (done_cnt - base_d) + (err_cnt - base_e), 0);
        exp_q.delete();
        run_vector('{8'hF4, 1'b1, 1'b0, 1, 0}, 1'b0);

        check("done_err_overlap", overlap_cnt, 0);
        check("pulse_width", wide_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
